// File: rtl/duck_pkg.sv
// Shared types and constants for the multiplexed 8-bit duck bus master.
package duck_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        STROBE,
        RECOVER
    } state_t;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_FLOAT = 8'h00;
    localparam int         CNT_W    = 4;

endpackage

// File: rtl/duck_bus_if.sv
// Core request -> multiplexed address/data bus cycle (ALE lo, ALE hi, RD/WR strobe, recover).
// Latency 3+STROBE_CYCLES (+ bus_wait stretch) to rsp_valid; req_ready only in IDLE, one transaction outstanding.
module duck_bus_if
    import duck_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    input  logic [7:0]  bus_ad_in,
    output logic [7:0]  bus_ad_out,
    output logic [7:0]  bus_ad_oe,
    output logic        bus_ale_lo,
    output logic        bus_ale_hi,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    input  logic        bus_wait
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_addr;
    logic             r_we;
    logic [7:0]       r_wdata;
    logic [7:0]       r_rdata;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hs;
    logic             w_strobe_done;

    assign w_hs          = req_valid && (r_state == IDLE);
    // bus_wait only matters once the minimum strobe width has elapsed
    assign w_strobe_done = (r_state == STROBE) && (r_cnt == '0) && !bus_wait;
    assign rsp_rdata     = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_hs) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
            end
            if (r_state == ADDR_HI) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == STROBE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_strobe_done && !r_we) begin
                r_rdata <= bus_ad_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        bus_ad_out  = 8'h00;
        bus_ad_oe   = OE_FLOAT;
        bus_ale_lo  = 1'b0;
        bus_ale_hi  = 1'b0;
        bus_rd_n    = 1'b1;
        bus_wr_n    = 1'b1;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ADDR_LO;
                end
            end
            ADDR_LO: begin
                bus_ad_out  = r_addr[7:0];
                bus_ad_oe   = OE_DRIVE;
                bus_ale_lo  = 1'b1;
                w_state_nxt = ADDR_HI;
            end
            ADDR_HI: begin
                bus_ad_out  = r_addr[15:8];
                bus_ad_oe   = OE_DRIVE;
                bus_ale_hi  = 1'b1;
                w_state_nxt = STROBE;
            end
            STROBE: begin
                if (r_we) begin
                    bus_ad_out = r_wdata;
                    bus_ad_oe  = OE_DRIVE;
                    bus_wr_n   = 1'b0;
                end else begin
                    bus_rd_n   = 1'b0;
                end
                if (w_strobe_done) begin
                    w_state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_duck_bus_if.sv
// Scoreboarded bench for duck_bus_if: bus phases traced per cycle, responses matched against queued expectations.
module tb_duck_bus_if;

    typedef struct packed {
        logic [7:0] rdata;
        logic [7:0] cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bus_ad_in;
    logic        bus_wait;

    logic        req_valid, req_ready, req_we, rsp_valid;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, rsp_rdata, bus_ad_out, bus_ad_oe;
    logic        bus_ale_lo, bus_ale_hi, bus_rd_n, bus_wr_n;

    logic        req_valid1, req_ready1, req_we1, rsp_valid1;
    logic [15:0] req_addr1;
    logic [7:0]  req_wdata1, rsp_rdata1, bus_ad_out1, bus_ad_oe1;
    logic        bus_ale_lo1, bus_ale_hi1, bus_rd_n1, bus_wr_n1;

    int checks   = 0;
    int failures = 0;

    rsp_t       sb[$];
    rsp_t       obs[$];
    logic [7:0] t_out[0:15];
    logic [7:0] t_oe[0:15];
    logic       t_lo[0:15];
    logic       t_hi[0:15];
    logic       t_rd[0:15];
    logic       t_wr[0:15];
    logic       t_rdy[0:15];
    int         t_viol;

    always #5 clk = ~clk;

    duck_bus_if #(.STROBE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_ad_in(bus_ad_in), .bus_ad_out(bus_ad_out), .bus_ad_oe(bus_ad_oe),
        .bus_ale_lo(bus_ale_lo), .bus_ale_hi(bus_ale_hi),
        .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_wait(bus_wait)
    );

    duck_bus_if #(.STROBE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .req_we(req_we1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .bus_ad_in(bus_ad_in), .bus_ad_out(bus_ad_out1), .bus_ad_oe(bus_ad_oe1),
        .bus_ale_lo(bus_ale_lo1), .bus_ale_hi(bus_ale_hi1),
        .bus_rd_n(bus_rd_n1), .bus_wr_n(bus_wr_n1), .bus_wait(bus_wait)
    );

    // Presents one request; index k of the trace arrays is cycle k after the handshake edge.
    task automatic trace(input bit sel, input logic [15:0] addr, input logic [15:0] addr2,
                         input logic we, input logic [7:0] wd, input int wstart, input int wlen,
                         input int ncyc, input int vld);
        logic rv;
        logic [7:0] rdat;
        int act;
        obs.delete();
        t_viol = 0;
        @(negedge clk);
        t_rdy[0] = sel ? req_ready1 : req_ready;
        if (sel) begin
            req_valid1 = 1'b1; req_addr1 = addr; req_we1 = we; req_wdata1 = wd;
        end else begin
            req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wd;
        end
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (sel) begin
                if (k == 1) req_addr1 = addr2;
                if (k >= vld) req_valid1 = 1'b0;
                t_out[k] = bus_ad_out1; t_oe[k] = bus_ad_oe1; t_lo[k] = bus_ale_lo1;
                t_hi[k] = bus_ale_hi1; t_rd[k] = bus_rd_n1; t_wr[k] = bus_wr_n1;
                t_rdy[k] = req_ready1; rv = rsp_valid1; rdat = rsp_rdata1;
            end else begin
                if (k == 1) req_addr = addr2;
                if (k >= vld) req_valid = 1'b0;
                t_out[k] = bus_ad_out; t_oe[k] = bus_ad_oe; t_lo[k] = bus_ale_lo;
                t_hi[k] = bus_ale_hi; t_rd[k] = bus_rd_n; t_wr[k] = bus_wr_n;
                t_rdy[k] = req_ready; rv = rsp_valid; rdat = rsp_rdata;
            end
            bus_wait = (k >= wstart) && (k < wstart + wlen);
            act = int'(t_lo[k]) + int'(t_hi[k]) + int'(!t_rd[k]) + int'(!t_wr[k]);
            if (act > 1) t_viol++;
            if (rv) obs.push_back({rdat, 8'(k)});
        end
        bus_wait = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_ad_oe, bus_ad_out} !== 16'h0000) begin
            failures++; $display("FAIL reset_bus oe/out got=%h exp=0000", {bus_ad_oe, bus_ad_out});
        end
        checks++;
        if ({bus_ale_lo, bus_ale_hi, bus_rd_n, bus_wr_n, rsp_valid} !== 5'b00110) begin
            failures++; $display("FAIL reset_strobes got=%b exp=00110",
                                 {bus_ale_lo, bus_ale_hi, bus_rd_n, bus_wr_n, rsp_valid});
        end
        checks++;
        if ({rsp_rdata, rsp_rdata1} !== 16'h0000) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0000", {rsp_rdata, rsp_rdata1});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_read();
        rsp_t e, o;
        int n;
        bus_ad_in = 8'h5C;
        sb.push_back({8'h5C, 8'd5});
        trace(1'b0, 16'h12AB, 16'h12AB, 1'b0, 8'h00, 0, 0, 8, 1);
        checks++;
        if (t_rdy[0] !== 1'b1) begin failures++; $display("FAIL read_ready got=%b exp=1", t_rdy[0]); end
        checks++;
        if ({t_lo[1], t_oe[1], t_out[1]} !== {1'b1, 8'hFF, 8'hAB}) begin
            failures++; $display("FAIL read_ale_lo got=%b/%h/%h exp=1/ff/ab", t_lo[1], t_oe[1], t_out[1]);
        end
        checks++;
        if ({t_hi[2], t_oe[2], t_out[2]} !== {1'b1, 8'hFF, 8'h12}) begin
            failures++; $display("FAIL read_ale_hi got=%b/%h/%h exp=1/ff/12", t_hi[2], t_oe[2], t_out[2]);
        end
        n = 0;
        for (int k = 1; k <= 8; k++) if (t_rd[k] === 1'b0) n++;
        checks++;
        if (n != 2 || t_rd[3] !== 1'b0 || t_rd[4] !== 1'b0) begin
            failures++; $display("FAIL read_rd_width got=%0d exp=2 (cycles 3,4)", n);
        end
        checks++;
        if ({t_oe[3], t_out[3]} !== 16'h0000) begin
            failures++; $display("FAIL read_strobe_bus got=%h/%h exp=00/00", t_oe[3], t_out[3]);
        end
        checks++;
        if (t_viol != 0) begin failures++; $display("FAIL read_exclusive got=%0d exp=0", t_viol); end
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL read_rsp got=none exp cyc=%0d rdata=%h", e.cyc, e.rdata);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL read_rsp got cyc=%0d rdata=%h exp cyc=%0d rdata=%h",
                                         o.cyc, o.rdata, e.cyc, e.rdata);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin failures++; $display("FAIL read_extra_rsp got=%0d exp=0", obs.size()); end
    endtask

    task automatic test_write();
        rsp_t e, o;
        int n, r;
        bus_ad_in = 8'h99;
        sb.push_back({8'h5C, 8'd5});
        trace(1'b0, 16'hFF00, 16'hFF00, 1'b1, 8'h3D, 0, 0, 8, 1);
        checks++;
        if ({t_out[1], t_out[2], t_out[3], t_out[4]} !== 32'h00FF3D3D) begin
            failures++; $display("FAIL write_ad_out got=%h %h %h %h exp=00 ff 3d 3d",
                                 t_out[1], t_out[2], t_out[3], t_out[4]);
        end
        checks++;
        if ({t_oe[1], t_oe[2], t_oe[3], t_oe[4], t_oe[5]} !== 40'hFFFFFFFF00) begin
            failures++; $display("FAIL write_oe got=%h %h %h %h %h exp=ff ff ff ff 00",
                                 t_oe[1], t_oe[2], t_oe[3], t_oe[4], t_oe[5]);
        end
        n = 0; r = 0;
        for (int k = 1; k <= 8; k++) begin
            if (t_wr[k] === 1'b0) n++;
            if (t_rd[k] === 1'b0) r++;
        end
        checks++;
        if (n != 2 || r != 0 || t_wr[3] !== 1'b0) begin
            failures++; $display("FAIL write_strobe got wr=%0d rd=%0d exp wr=2 rd=0", n, r);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL write_rsp got=none exp cyc=%0d rdata=%h", e.cyc, e.rdata);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL write_rsp got cyc=%0d rdata=%h exp cyc=%0d rdata=%h",
                                         o.cyc, o.rdata, e.cyc, e.rdata);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin failures++; $display("FAIL write_extra_rsp got=%0d exp=0", obs.size()); end
    endtask

    task automatic test_wait();
        rsp_t e, o;
        int n;
        bus_ad_in = 8'hA7;
        sb.push_back({8'hA7, 8'd7});
        trace(1'b0, 16'h0042, 16'h0042, 1'b0, 8'h00, 3, 3, 9, 1);
        n = 0;
        for (int k = 1; k <= 9; k++) if (t_rd[k] === 1'b0) n++;
        checks++;
        if (n != 4) begin failures++; $display("FAIL wait_rd_width got=%0d exp=4", n); end
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL wait_rsp got=none exp cyc=%0d rdata=%h", e.cyc, e.rdata);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL wait_rsp got cyc=%0d rdata=%h exp cyc=%0d rdata=%h",
                                         o.cyc, o.rdata, e.cyc, e.rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e, o;
        int n;
        bus_ad_in = 8'h31;
        sb.push_back({8'h31, 8'd5});
        sb.push_back({8'h31, 8'd11});
        // Address changes during the first transaction must not leak into it.
        trace(1'b0, 16'h1234, 16'h5678, 1'b0, 8'h00, 0, 0, 13, 7);
        n = 0;
        for (int k = 1; k <= 5; k++) if (t_rdy[k] !== 1'b0) n++;
        checks++;
        if (n != 0 || t_rdy[6] !== 1'b1) begin
            failures++; $display("FAIL b2b_ready got high_in_txn=%0d idle=%b exp 0/1", n, t_rdy[6]);
        end
        checks++;
        if ({t_hi[2], t_out[2]} !== {1'b1, 8'h12}) begin
            failures++; $display("FAIL b2b_first_hi got=%b/%h exp=1/12", t_hi[2], t_out[2]);
        end
        checks++;
        if ({t_lo[7], t_out[7], t_hi[8], t_out[8]} !== {1'b1, 8'h78, 1'b1, 8'h56}) begin
            failures++; $display("FAIL b2b_second_addr got=%b/%h %b/%h exp=1/78 1/56",
                                 t_lo[7], t_out[7], t_hi[8], t_out[8]);
        end
        checks++;
        if (t_viol != 0) begin failures++; $display("FAIL b2b_exclusive got=%0d exp=0", t_viol); end
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL b2b_rsp got=none exp cyc=%0d rdata=%h", e.cyc, e.rdata);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL b2b_rsp got cyc=%0d rdata=%h exp cyc=%0d rdata=%h",
                                         o.cyc, o.rdata, e.cyc, e.rdata);
                end
            end
        end
        checks++;
        if (obs.size() != 0) begin failures++; $display("FAIL b2b_extra_rsp got=%0d exp=0", obs.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        trace(1'b0, 16'h0100, 16'h0100, 1'b1, 8'h77, 0, 0, 3, 1);
        checks++;
        if ({t_wr[3], t_oe[3]} !== {1'b0, 8'hFF}) begin
            failures++; $display("FAIL midrst_strobe got=%b/%h exp=0/ff", t_wr[3], t_oe[3]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_wr_n, bus_ad_oe, bus_ad_out} !== {1'b1, 8'h00, 8'h00}) begin
            failures++; $display("FAIL midrst_async got=%b/%h/%h exp=1/00/00", bus_wr_n, bus_ad_oe, bus_ad_out);
        end
        n = 0;
        @(negedge clk);
        if (rsp_valid === 1'b1) n++;
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
            end
            if (rsp_valid !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin failures++; $display("FAIL midrst_no_rsp got=%0d exp=0", n); end
    endtask

    task automatic test_strobe1();
        rsp_t e, o;
        int n;
        bus_ad_in = 8'hE4;
        sb.push_back({8'hE4, 8'd4});
        trace(1'b1, 16'h3456, 16'h3456, 1'b0, 8'h00, 0, 0, 6, 1);
        n = 0;
        for (int k = 1; k <= 6; k++) if (t_rd[k] === 1'b0) n++;
        checks++;
        if (n != 1 || t_rd[3] !== 1'b0) begin failures++; $display("FAIL s1_rd_width got=%0d exp=1", n); end
        while (sb.size() != 0) begin
            e = sb.pop_front(); checks++;
            if (obs.size() == 0) begin
                failures++; $display("FAIL s1_rsp got=none exp cyc=%0d rdata=%h", e.cyc, e.rdata);
            end else begin
                o = obs.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL s1_rsp got cyc=%0d rdata=%h exp cyc=%0d rdata=%h",
                                         o.cyc, o.rdata, e.cyc, e.rdata);
                end
            end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
        req_valid1 = 1'b0; req_addr1 = '0; req_we1 = 1'b0; req_wdata1 = '0;
        bus_ad_in = 8'h00; bus_wait = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        test_strobe1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
